router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
Packet transmitter that drives the router's input side (pkt_vld, din, busy, err). It accepts a packet request (addr, len), buffers the payload from a local streaming source, then sends the packet byte-serially. The packet is a header byte, len payload bytes and an XOR parity byte, and the transmitter stalls whenever the router asserts busy. After the parity byte it samples the router's err, then reports completion to the requester.

Parameters:
ERR_WAIT, 3, cycles after parity-byte acceptance during which err is sampled (1..15)
GAP, 2, minimum idle cycles with pkt_vld=0 between packets (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  request strobe, sampled when req_rdy=1
addr  in  2  destination port 0..2; 3 is illegal
len  in  6  payload length 1..63; 0 is illegal
req_rdy  out  1  idle and able to accept start
pl_din  in  8  payload byte from local source
pl_vld  in  1  pl_din valid
pl_rdy  out  1  transmitter accepts a payload byte (beat = pl_vld & pl_rdy)
busy  in  1  router stall; the presented byte is not consumed
err  in  1  router parity-error flag
pkt_vld  out  1  high on header and payload bytes, low on the parity byte
dout  out  8  byte to router din
done  out  1  one-cycle pulse at packet completion
tx_err  out  1  valid with done; 1 = err seen in the ERR_WAIT window
bad_req  out  1  one-cycle pulse when start carries an illegal addr or len

Behaviour:
- Reset: state IDLE; req_rdy=1; pl_rdy=0; pkt_vld=0; dout=0; done=0; tx_err=0; bad_req=0; all counters and the parity register are 0. Reset mid-packet aborts immediately, with no done pulse.
- All outputs are registered.
- Consumption rule: the router consumes the presented byte on a rising edge where busy=0. While busy=1, dout and pkt_vld hold their values.
- IDLE: req_rdy=1.
  - start with addr=3 or len=0: pulse bad_req the next cycle and stay in IDLE.
  - Legal start: latch addr and len, set hdr={len,addr}, set parity=hdr, clear wcnt, go to LOAD.
- LOAD: pl_rdy=1.
  - Each beat writes buf[wcnt]=pl_din, updates parity^=pl_din and increments wcnt.
  - On the beat where wcnt==len-1, go to HEADER and drop pl_rdy the following cycle.
  - pl_vld gaps simply wait; there is no timeout.
- HEADER: pkt_vld=1, dout=hdr. Consumed header -> PAYLOAD with rcnt=0.
- PAYLOAD: pkt_vld=1, dout=buf[rcnt].
  - Consumed byte increments rcnt.
  - Consumption of byte len-1 -> PARITY.
  - With busy=0 throughout, bytes appear on consecutive cycles.
- PARITY: pkt_vld=0, dout=parity. Consumed -> ERRCHK with ecnt=0.
- ERRCHK: runs ERR_WAIT cycles with pkt_vld=0 and dout=0.
  - Any cycle with err=1 sets err_seen.
  - Last cycle -> GAP, with done=1 and tx_err=err_seen in the same cycle.
- GAP: req_rdy=0 for GAP cycles, then IDLE.
- Latency with pl_vld=1 and busy=0 throughout:
  - Legal start accepted on edge T.
  - Beats on edges T+1..T+len.
  - Header visible from cycle T+len+1; payload bytes follow on the next len cycles; parity byte follows them.
- Boundaries:
  - len=63 uses all buffer entries 0..62; wcnt and rcnt are 6 bits and never wrap past 62.
  - busy asserted on the header, on any payload byte or on the parity byte stalls exactly that byte.
  - start while req_rdy=0 is ignored.
  - err outside the ERRCHK window is ignored.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, HEADER, PAYLOAD, PARITY, ERRCHK, GAP), the ADDR_ILLEGAL=2'd3 constant, MAX_LEN=63, and a header-pack function {len,addr}.
- Sub-module router_tx_buf: 64x8 synchronous-write register array with a combinational read port. The read is combinational so that dout updates in the same cycle as rcnt.

Test Plan:
- addr=1, len=3, payload 11,22,33, busy=0 -> dout sequence 0D(pkt_vld=1), 11, 22, 33, then 0D with pkt_vld=0; done=1 and tx_err=0 three cycles later.
- Same packet with busy=1 for 4 cycles while byte 22 is presented -> 22 and pkt_vld held 4 cycles; the sequence is otherwise unchanged.
- start with addr=3 len=5, then addr=0 len=0 -> bad_req pulses twice, pl_rdy stays 0, pkt_vld never rises.
- addr=2, len=63, payload 00..3E with pl_vld toggling every other cycle -> header FE; 63 payload bytes in order; parity = FE^XOR(00..3E).
- addr=0, len=2, err driven high on the 2nd ERRCHK cycle -> done with tx_err=1. Next packet: req_rdy=0 for GAP cycles after done, then 1.
- rst asserted on the 2nd payload byte -> the next cycle pkt_vld=0, dout=0 and req_rdy=1; a new packet then transmits correctly.

Source files
------------

// File: rtl/router_pkt_tx_pkg.sv
// router_pkt_tx_pkg
// Shared definitions for the router packet transmitter: FSM state encoding,
// illegal-address constant, maximum payload length, payload buffer depth and
// the header-byte packing helper.
package router_pkt_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_ERRCHK,
    S_GAP
  } state_e;

  localparam logic [1:0] ADDR_ILLEGAL = 2'd3;
  localparam int         MAX_LEN      = 63;
  // One spare entry so the buffer is a power of two; entry 63 is never used.
  localparam int         BUF_DEPTH    = MAX_LEN + 1;

  // Header byte: payload length in the upper six bits, destination port below.
  function automatic logic [7:0] pack_hdr(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf
// 64x8 payload buffer: synchronous write, combinational read.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write address (0..62)
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, follows raddr_i combinationally
module router_tx_buf
  import router_pkt_tx_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [5:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read lets the transmitter register the byte for the
  // upcoming read index in the same cycle the index changes.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx
// Packet transmitter feeding the router input side. Accepts a request
// (addr, len), buffers len payload bytes from a local stream, then sends
// header {len,addr}, the payload and an XOR parity byte, stalling on busy.
// After parity it watches err for ERR_WAIT cycles, pulses done with tx_err,
// and holds off new requests for GAP cycles.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, addr, len    request strobe and fields (sampled when req_rdy=1)
//   req_rdy             idle, request can be accepted
//   pl_din, pl_vld      payload stream in; pl_rdy accepts a byte
//   busy, err           router stall and parity-error flag
//   pkt_vld, dout       byte to router (pkt_vld low on parity byte)
//   done, tx_err        completion pulse and error status
//   bad_req             pulse on illegal request
// All outputs are registered.
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int unsigned ERR_WAIT = 3,
  parameter int unsigned GAP      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] addr,
  input  logic [5:0] len,
  output logic       req_rdy,
  input  logic [7:0] pl_din,
  input  logic       pl_vld,
  output logic       pl_rdy,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_vld,
  output logic [7:0] dout,
  output logic       done,
  output logic       tx_err,
  output logic       bad_req
);

  localparam logic [3:0] ERRCHK_LAST = 4'(ERR_WAIT - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP - 1);

  state_e     state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] parity_q, parity_d;
  logic [5:0] wcnt_q, wcnt_d;
  logic [5:0] rcnt_q, rcnt_d;
  logic [3:0] ecnt_q, ecnt_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic       err_seen_q, err_seen_d;

  logic       req_rdy_q, req_rdy_d;
  logic       pl_rdy_q, pl_rdy_d;
  logic       pkt_vld_q, pkt_vld_d;
  logic [7:0] dout_q, dout_d;
  logic       done_q, done_d;
  logic       tx_err_q, tx_err_d;
  logic       bad_req_q, bad_req_d;

  logic       buf_we;
  logic [7:0] buf_rdata;
  logic       pl_beat;

  assign pl_beat = pl_vld & pl_rdy_q;

  router_tx_buf u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wcnt_q),
    .wdata_i (pl_din),
    .raddr_i (rcnt_d),
    .rdata_o (buf_rdata)
  );

  // Next-state and bookkeeping.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    hdr_d      = hdr_q;
    parity_d   = parity_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    ecnt_d     = ecnt_q;
    gcnt_d     = gcnt_q;
    err_seen_d = err_seen_q;
    buf_we     = 1'b0;
    done_d     = 1'b0;
    tx_err_d   = 1'b0;
    bad_req_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (addr == ADDR_ILLEGAL || len == 6'd0) begin
            bad_req_d = 1'b1;
          end else begin
            len_d    = len;
            hdr_d    = pack_hdr(len, addr);
            parity_d = pack_hdr(len, addr);
            wcnt_d   = 6'd0;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (pl_beat) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ pl_din;
          wcnt_d   = wcnt_q + 6'd1;
          if (wcnt_q == len_q - 6'd1) begin
            state_d = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          rcnt_d  = 6'd0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          // rcnt stops at len-1 so it never indexes past entry 62.
          if (rcnt_q == len_q - 6'd1) begin
            state_d = S_PARITY;
          end else begin
            rcnt_d = rcnt_q + 6'd1;
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          ecnt_d     = 4'd0;
          err_seen_d = 1'b0;
          state_d    = S_ERRCHK;
        end
      end
      S_ERRCHK: begin
        err_seen_d = err_seen_q | err;
        ecnt_d     = ecnt_q + 4'd1;
        if (ecnt_q == ERRCHK_LAST) begin
          done_d   = 1'b1;
          tx_err_d = err_seen_q | err;
          gcnt_d   = 4'd0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + 4'd1;
        if (gcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they change on the
  // same edge as the state. Holding under busy falls out naturally because
  // state, rcnt and parity do not move.
  always_comb begin
    req_rdy_d = (state_d == S_IDLE);
    pl_rdy_d  = (state_d == S_LOAD);
    pkt_vld_d = (state_d == S_HEADER) || (state_d == S_PAYLOAD);
    case (state_d)
      S_HEADER:  dout_d = hdr_d;
      S_PAYLOAD: dout_d = buf_rdata;
      S_PARITY:  dout_d = parity_d;
      default:   dout_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= 6'd0;
      hdr_q      <= 8'd0;
      parity_q   <= 8'd0;
      wcnt_q     <= 6'd0;
      rcnt_q     <= 6'd0;
      ecnt_q     <= 4'd0;
      gcnt_q     <= 4'd0;
      err_seen_q <= 1'b0;
      req_rdy_q  <= 1'b1;
      pl_rdy_q   <= 1'b0;
      pkt_vld_q  <= 1'b0;
      dout_q     <= 8'd0;
      done_q     <= 1'b0;
      tx_err_q   <= 1'b0;
      bad_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hdr_q      <= hdr_d;
      parity_q   <= parity_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      ecnt_q     <= ecnt_d;
      gcnt_q     <= gcnt_d;
      err_seen_q <= err_seen_d;
      req_rdy_q  <= req_rdy_d;
      pl_rdy_q   <= pl_rdy_d;
      pkt_vld_q  <= pkt_vld_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      tx_err_q   <= tx_err_d;
      bad_req_q  <= bad_req_d;
    end
  end

  assign req_rdy = req_rdy_q;
  assign pl_rdy  = pl_rdy_q;
  assign pkt_vld = pkt_vld_q;
  assign dout    = dout_q;
  assign done    = done_q;
  assign tx_err  = tx_err_q;
  assign bad_req = bad_req_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx
// Scoreboard bench for router_pkt_tx: stimulus pushes expected bytes and
// completion status into queues; a negedge monitor pops and compares every
// byte the router consumes and every done pulse.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] addr;
  logic [5:0] len;
  logic       req_rdy;
  logic [7:0] pl_din;
  logic       pl_vld, pl_rdy, busy, err, pkt_vld;
  logic [7:0] dout;
  logic       done, tx_err, bad_req;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       vld;
    logic [7:0] b;
  } item_t;

  item_t      exp_q[$];
  bit         exp_done_q[$];
  item_t      it;
  bit         exp_err;
  logic [7:0] pay [64];
  bit         par_pending = 1'b0;
  bit         prev_hold   = 1'b0;
  logic [8:0] prev_out    = 9'd0;
  int         nbytes      = 0;

  always #5 clk = ~clk;

  router_pkt_tx #(.ERR_WAIT(3), .GAP(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .len     (len),
    .req_rdy (req_rdy),
    .pl_din  (pl_din),
    .pl_vld  (pl_vld),
    .pl_rdy  (pl_rdy),
    .busy    (busy),
    .err     (err),
    .pkt_vld (pkt_vld),
    .dout    (dout),
    .done    (done),
    .tx_err  (tx_err),
    .bad_req (bad_req)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  // Monitor: a byte is consumed on an edge with busy=0 while a header/payload
  // byte (pkt_vld=1) or the parity byte right after them is presented.
  always @(negedge clk) begin
    if (rst) begin
      par_pending = 1'b0;
      prev_hold   = 1'b0;
    end else begin
      if (prev_hold) chk("busy_hold", {23'd0, pkt_vld, dout}, {23'd0, prev_out});
      prev_hold = 1'b0;
      if (pkt_vld || par_pending) begin
        if (busy) begin
          prev_hold = 1'b1;
          prev_out  = {pkt_vld, dout};
        end else begin
          nbytes++;
          $display("byte %0d: pkt_vld=%0b dout=%02h", nbytes, pkt_vld, dout);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0b/%02h required no byte", pkt_vld, dout);
          end else begin
            it = exp_q.pop_front();
            chk("tx_byte", {23'd0, pkt_vld, dout}, {23'd0, it.vld, it.b});
          end
          par_pending = pkt_vld;
        end
      end
      if (done) begin
        $display("done: tx_err=%0b", tx_err);
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required 0");
        end else begin
          exp_err = exp_done_q.pop_front();
          chk("tx_err", {31'd0, tx_err}, {31'd0, exp_err});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [7:0] hdr, input int n, input logic [7:0] par, input bit e);
    exp_q.push_back('{vld: 1'b1, b: hdr});
    for (int i = 0; i < n; i++) exp_q.push_back('{vld: 1'b1, b: pay[i]});
    exp_q.push_back('{vld: 1'b0, b: par});
    exp_done_q.push_back(e);
  endtask

  task automatic do_start(input logic [1:0] a, input logic [5:0] l);
    int n = 0;
    while (!req_rdy && n < 200) begin
      tick();
      n++;
    end
    if (!req_rdy) begin
      checks++;
      errors++;
      $display("FAIL req_rdy_wait: got req_rdy=0 required 1 within 200 cycles");
    end
    start = 1'b1;
    addr  = a;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Supplies n payload bytes; with toggle, pl_vld is high every other cycle.
  // The header must be presented immediately after the last beat.
  task automatic feed(input int n, input bit toggle, input logic [7:0] hdr);
    int  i   = 0;
    int  cyc = 0;
    bit  beat;
    while (i < n && cyc < 1000) begin
      pl_vld = toggle ? (cyc[0] == 1'b0) : 1'b1;
      pl_din = pay[i];
      beat   = pl_vld && pl_rdy;
      tick();
      if (beat) i++;
      cyc++;
    end
    pl_vld = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: got %0d beats required %0d", i, n);
    end
    chk("hdr_latency", {22'd0, pl_rdy, pkt_vld, dout}, {22'd0, 1'b0, 1'b1, hdr});
  endtask

  task automatic wait_show(input logic [7:0] b, input logic v);
    int n = 0;
    while (!(pkt_vld === v && dout === b) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL wait_byte: got %0b/%02h required %0b/%02h", pkt_vld, dout, v, b);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 500) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 required 1 within 500 cycles");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr = 2'd0; len = 6'd0;
    pl_din = 8'd0; pl_vld = 1'b0; busy = 1'b0; err = 1'b0;
    tick();
    tick();
    chk("reset_outs", {18'd0, req_rdy, pl_rdy, pkt_vld, dout, done, tx_err, bad_req},
        {18'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000});
    rst = 1'b0;

    // Basic packet; err outside the window must be ignored.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    push_expect(8'h0D, 3, 8'h0D, 1'b0);
    err = 1'b1;
    do_start(2'd1, 6'd3);
    feed(3, 1'b0, 8'h0D);
    err = 1'b0;
    wait_done();
    tick();

    // Same packet with a 4-cycle stall on byte 22.
    push_expect(8'h0D, 3, 8'h0D, 1'b0);
    do_start(2'd1, 6'd3);
    feed(3, 1'b0, 8'h0D);
    wait_show(8'h22, 1'b1);
    busy = 1'b1;
    repeat (4) tick();
    busy = 1'b0;
    wait_done();
    tick();

    // Illegal requests.
    do_start(2'd3, 6'd5);
    chk("bad_req_addr", {29'd0, bad_req, pl_rdy, req_rdy}, {29'd0, 3'b101});
    do_start(2'd0, 6'd0);
    chk("bad_req_len", {29'd0, bad_req, pl_rdy, req_rdy}, {29'd0, 3'b101});
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bad_req_quiet", {29'd0, bad_req, pl_rdy, pkt_vld}, 32'd0);
    end

    // Full-length packet with gappy payload source.
    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    push_expect(8'hFE, 63, 8'hC1, 1'b0);
    do_start(2'd2, 6'd63);
    feed(63, 1'b1, 8'hFE);
    wait_done();
    tick();

    // err on the second error-window cycle, then GAP behaviour.
    pay[0] = 8'hAA; pay[1] = 8'h55;
    push_expect(8'h08, 2, 8'hF7, 1'b1);
    do_start(2'd0, 6'd2);
    feed(2, 1'b0, 8'h08);
    wait_show(8'hF7, 1'b0);
    tick();
    tick();
    err = 1'b1;
    tick();
    err = 1'b0;
    wait_done();
    chk("gap_rdy0", {31'd0, req_rdy}, 32'd0);
    start = 1'b1; addr = 2'd1; len = 6'd1;   // must be ignored
    tick();
    start = 1'b0;
    chk("gap_rdy1", {31'd0, req_rdy}, 32'd0);
    tick();
    chk("gap_idle", {30'd0, req_rdy, pl_rdy}, {30'd0, 2'b10});
    pay[0] = 8'h3C;
    push_expect(8'h05, 1, 8'h39, 1'b0);
    do_start(2'd1, 6'd1);
    feed(1, 1'b0, 8'h05);
    wait_done();
    tick();

    // Reset in the middle of the payload.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    push_expect(8'h0D, 3, 8'h0D, 1'b0);
    do_start(2'd1, 6'd3);
    feed(3, 1'b0, 8'h0D);
    wait_show(8'h22, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outs", {22'd0, pkt_vld, dout, req_rdy}, {22'd0, 1'b0, 8'h00, 1'b1});
    exp_q.delete();
    exp_done_q.delete();
    repeat (8) tick();
    pay[0] = 8'h5A;
    push_expect(8'h06, 1, 8'h5C, 1'b0);
    do_start(2'd2, 6'd1);
    feed(1, 1'b0, 8'h06);
    wait_done();
    tick();

    for (int n = 0; n < 100 && (exp_q.size() != 0 || exp_done_q.size() != 0); n++) tick();
    checks++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d bytes %0d dones pending required 0", exp_q.size(), exp_done_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
